// File: rtl/uart_reg_writer.sv
// uart_reg_writer
// Parses framed register-write commands from the UART RX byte stream and
// issues single-word writes into port B of the camera/IPM register BRAM.
//
// Frame: HEADER, ADDR, D3, D2, D1, D0, CHK
//   data = {D3[0], D2, D1, D0}, D3[7:1] must be zero
//   CHK  = ADDR ^ D3 ^ D2 ^ D1 ^ D0
//
// Ports:
//   clk          system clock
//   i_reset      synchronous, active-high reset
//   i_enable     BRAM port B clock enable; a write commits only while high
//   i_configured default_reg_writer finished; bytes are ignored while low
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   o_addr       BRAM port B address (holds last value outside WRITE)
//   o_data       BRAM port B write data (holds last value outside WRITE)
//   o_we         BRAM port B write enable, high for the whole WRITE state
//   o_busy       high whenever a frame is in progress or a write is pending
//   o_ack        one-cycle pulse on the commit cycle
//   o_err        one-cycle pulse for each rejected frame / stray byte
module uart_reg_writer #(
    parameter int             DEPTH      = 88,
    parameter int             ADDR_WIDTH = 7,
    parameter int             DATA_WIDTH = 25,
    parameter logic [7:0]     HEADER     = 8'hA5,
    parameter int             TIMEOUT    = 100000,
    parameter int             TO_WIDTH   = 17
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_configured,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_we,
    output logic                  o_busy,
    output logic                  o_ack,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_D3    = 3'd2,
        S_D2    = 3'd3,
        S_D1    = 3'd4,
        S_D0    = 3'd5,
        S_CHK   = 3'd6,
        S_WRITE = 3'd7
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [7:0]          addr_byte_r;
    logic [7:0]          d3_r;
    logic [7:0]          d2_r;
    logic [7:0]          d1_r;
    logic [7:0]          d0_r;
    logic [TO_WIDTH-1:0] to_cnt_r;
    logic                err_pend_r;
    logic                in_frame_s;
    logic                frame_ok_s;
    logic                timeout_s;
    logic                commit_s;
    logic                err_event_s;

    function automatic logic [7:0] frame_xor(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d,
                                             input logic [7:0] e);
        return a ^ b ^ c ^ d ^ e;
    endfunction

    assign in_frame_s = (state_r != S_IDLE) && (state_r != S_WRITE);
    assign frame_ok_s = (i_rx_data == frame_xor(addr_byte_r, d3_r, d2_r, d1_r, d0_r))
                     && (addr_byte_r < 8'(DEPTH))
                     && (d3_r[7:1] == 7'd0);
    // A byte in the same cycle always wins over the timeout.
    assign timeout_s  = in_frame_s && !i_rx_valid
                     && (to_cnt_r == TO_WIDTH'(TIMEOUT - 1));
    assign commit_s   = (state_r == S_WRITE) && i_enable;

    assign o_we   = (state_r == S_WRITE);
    assign o_busy = (state_r != S_IDLE);
    assign o_ack  = commit_s;
    // An error raised while a write is pending is held back for one cycle if
    // it would land on the commit cycle, so o_err and o_ack never coincide.
    assign o_err  = err_pend_r && !commit_s;

    // Next-state and error-event logic.
    always_comb begin
        state_s     = state_r;
        err_event_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (i_configured && i_rx_valid && (i_rx_data == HEADER)) begin
                    state_s = S_ADDR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR, S_D3, S_D2, S_D1, S_D0: begin
                if (!i_configured) begin
                    state_s = S_IDLE;
                end else if (i_rx_valid) begin
                    state_s = state_t'(state_r + 3'd1);
                end else if (timeout_s) begin
                    state_s     = S_IDLE;
                    err_event_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            S_CHK: begin
                if (!i_configured) begin
                    state_s = S_IDLE;
                end else if (i_rx_valid) begin
                    if (frame_ok_s) begin
                        state_s = S_WRITE;
                    end else begin
                        state_s     = S_IDLE;
                        err_event_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_s     = S_IDLE;
                    err_event_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            S_WRITE: begin
                // Stray bytes are flagged but never cancel the pending write.
                err_event_s = i_rx_valid;
                if (commit_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WRITE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, byte latches, timeout counter, output address/data and error pulse.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r     <= S_IDLE;
            addr_byte_r <= 8'd0;
            d3_r        <= 8'd0;
            d2_r        <= 8'd0;
            d1_r        <= 8'd0;
            d0_r        <= 8'd0;
            to_cnt_r    <= '0;
            err_pend_r  <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
        end else begin
            state_r    <= state_s;
            err_pend_r <= err_event_s || (err_pend_r && commit_s);

            if (!in_frame_s || i_rx_valid) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + {{(TO_WIDTH-1){1'b0}}, 1'b1};
            end

            if (i_rx_valid) begin
                case (state_r)
                    S_ADDR:  addr_byte_r <= i_rx_data;
                    S_D3:    d3_r        <= i_rx_data;
                    S_D2:    d2_r        <= i_rx_data;
                    S_D1:    d1_r        <= i_rx_data;
                    S_D0:    d0_r        <= i_rx_data;
                    default: d0_r        <= d0_r;
                endcase
            end

            // Address/data only change when a frame is accepted, so they hold
            // their last values while o_we is low.
            if ((state_r == S_CHK) && (state_s == S_WRITE)) begin
                o_addr <= addr_byte_r[ADDR_WIDTH-1:0];
                o_data <= DATA_WIDTH'({d3_r[0], d2_r, d1_r, d0_r});
            end
        end
    end

endmodule

// File: doc/uart_reg_writer.md
Name: uart_reg_writer

Overview:
- Upstream register-write source for the 88×25-bit camera/IPM register BRAM, port B.
- Parses framed write commands from the UART RX byte stream and issues single-word writes.
- Runs beside default_reg_writer. Port B mux selects this block once i_configured is high.
- Lets the host retune IPM/camera registers at run time; reg_reader picks the values up on port A.

Parameters:
- DEPTH, 88, number of valid register addresses; addr >= DEPTH is rejected.
- ADDR_WIDTH, 7, width of o_addr.
- DATA_WIDTH, 25, width of o_data.
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 100000, max clk cycles between bytes inside a frame.
- TO_WIDTH, 17, counter width for TIMEOUT.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  clock enable shared with BRAM port B enb; a write commits only on a cycle with i_enable=1
- i_configured  in  1  default_reg_writer done; bytes are discarded while low
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_addr  out  ADDR_WIDTH  BRAM port B address
- o_data  out  DATA_WIDTH  BRAM port B write data
- o_we  out  1  BRAM port B write enable
- o_busy  out  1  high in any state other than IDLE
- o_ack  out  1  one-cycle pulse on the cycle the write commits
- o_err  out  1  one-cycle pulse on any frame rejection

Behaviour:
- Frame format, 7 bytes:
  - HEADER, ADDR, D3, D2, D1, D0, CHK.
  - Data = {D3[0], D2, D1, D0}. D3[7:1] must be 0.
  - CHK = ADDR^D3^D2^D1^D0.
- FSM states: IDLE, ADDR, D3, D2, D1, D0, CHK, WRITE. Transitions below happen on the cycle with i_rx_valid=1.
- IDLE:
  - Stays in IDLE while i_configured=0.
  - A byte == HEADER moves to ADDR. Any other byte is silently dropped; no o_err.
- ADDR: latch byte, go to D3.
- D3..D0: latch each byte, advance one state per byte.
- CHK:
  - Go to WRITE if all hold: checksum matches, ADDR < DEPTH, D3[7:1]==0.
  - Otherwise pulse o_err and return to IDLE.
- WRITE:
  - o_addr and o_data are driven from the latches and o_we=1.
  - Held until the first cycle with i_enable=1. That cycle is the commit: o_ack=1 for that cycle.
  - Next cycle: o_we=0, state IDLE.
  - If i_enable is already high on WRITE entry, the commit happens in that first cycle; latency is 1 clk after the CHK byte strobe.
- Bytes in WRITE: any i_rx_valid during WRITE is dropped and pulses o_err. The pending write still commits.
- Timeout:
  - Counter clears on every accepted byte and counts clk cycles in ADDR..CHK.
  - Reaching TIMEOUT pulses o_err and returns to IDLE. No write.
- A byte and a timeout in the same cycle: the byte wins and the counter clears.
- o_err and o_ack are never high in the same cycle.
- i_configured falling mid-frame aborts to IDLE with no o_err. In WRITE, the pending write still completes.
- Reset values: state IDLE, o_addr=0, o_data=0, o_we=0, o_busy=0, o_ack=0, o_err=0, counter 0.
- Reset mid-frame or in WRITE: aborts immediately and the pending write is lost.
- o_addr/o_data hold their last values outside WRITE; o_we=0 guarantees no spurious writes.

Test Plan:
- Basic write: i_configured=1, i_enable=1, bytes A5,10,01,23,45,67,10 → one cycle with o_we=1, o_addr=7'h10, o_data=25'h1234567, o_ack=1; BRAM word 16 reads back 25'h1234567 via reg_reader port A.
- Enable stall: same frame with i_enable pulsing 1-in-4 → o_we held high until the first i_enable=1 cycle, o_ack there, exactly one write.
- Rejections, each giving one o_err pulse, no o_we, return to IDLE:
  - bad CHK: A5,10,01,23,45,67,11
  - ADDR=0x58 (88)
  - D3=0x03
- Timeout: A5,10 then silence for TIMEOUT cycles → o_err pulse, o_busy=0. Following valid frame is accepted normally.
- Gating and noise: bytes 00,FF,A5... sent while i_configured=0 → no state change, o_busy stays 0. After i_configured=1, leading 00,FF are dropped without o_err and the A5 frame is written.
- Reset mid-frame: i_reset=1 after D2 → all outputs 0. Next full frame writes correctly; no remnant of the aborted frame.
